// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants, FSM state encodings and the queue entry layout for the prefetch queue.
package inst_prefetch_queue_pkg;

  localparam logic [31:0] PC_INITIAL      = 32'h0000_0000;
  localparam int          PFQ_STATE_WIDTH = 2;

  typedef enum logic [PFQ_STATE_WIDTH-1:0] {
    PFQ_IDLE = 2'd0,
    PFQ_REQ  = 2'd1,
    PFQ_DROP = 2'd2
  } pfq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pfq_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// Synchronous DEPTH x {pc, inst} FIFO; pointers carry one extra wrap bit so full and empty differ.
module inst_prefetch_queue_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  pfq_entry_t   i_data,
  output logic [AW:0]  o_count,
  output logic         o_empty,
  output pfq_entry_t   o_head
);

  pfq_entry_t  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_pop;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (o_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; validity is carried entirely by the pointers.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetch FSM, fetch pointer, credit check and head mux.
// Optional combinational ack-to-head bypass is enabled by defining PREFETCH_BYPASS_EN.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memAck,
  input  logic [31:0] i_memData,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_instValid,
  output logic [31:0] o_instPc,
  output logic [31:0] o_inst,
  input  logic        i_instTake
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  pfq_state_t  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;

  logic [AW:0] w_count;
  logic [AW:0] w_count_next;
  logic        w_empty;
  pfq_entry_t  w_head;
  logic        w_ack_ok;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;

  assign w_ack_ok = (r_state == PFQ_REQ) && i_memAck && !i_redirect;

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = w_ack_ok && w_empty;
  assign w_push   = w_ack_ok && !(w_bypass && i_instTake);
`else
  assign w_bypass = 1'b0;
  assign w_push   = w_ack_ok;
`endif

  assign w_pop        = i_instTake && !w_empty && !i_redirect;
  assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  inst_prefetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  ('{pc: r_req_addr, inst: i_memData}),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= PFQ_IDLE;
      r_fetch_pc <= PC_INITIAL;
      r_req_addr <= PC_INITIAL;
    end else begin
      case (r_state)
        PFQ_IDLE: begin
          if (i_redirect) begin
            r_fetch_pc <= i_redirectPc;
          end else if (w_count < DEPTH_C) begin
            r_state    <= PFQ_REQ;
            r_req_addr <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        PFQ_REQ: begin
          if (i_redirect) begin
            r_fetch_pc <= i_redirectPc;
            r_state    <= i_memAck ? PFQ_IDLE : PFQ_DROP;
          end else if (i_memAck) begin
            // Issue back-to-back only if the post-ack occupancy still leaves a free slot.
            if (w_count_next < DEPTH_C) begin
              r_req_addr <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
              r_state <= PFQ_IDLE;
            end
          end
        end
        PFQ_DROP: begin
          if (i_redirect) r_fetch_pc <= i_redirectPc;
          if (i_memAck)   r_state    <= PFQ_IDLE;
        end
        default: r_state <= PFQ_IDLE;
      endcase
    end
  end

  assign o_memReq    = (r_state != PFQ_IDLE);
  assign o_memAddr   = r_req_addr;
  assign o_instValid = w_bypass || !w_empty;
  assign o_instPc    = w_bypass ? r_req_addr : w_head.pc;
  assign o_inst      = w_bypass ? i_memData  : w_head.inst;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue (DEPTH=4); bypass case runs when PREFETCH_BYPASS_EN is defined.
module tb_inst_prefetch_queue;
  import inst_prefetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_take = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acks;
  logic [31:0] last_addr;

  inst_prefetch_queue #(.DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_memReq     (mem_req),
    .o_memAddr    (mem_addr),
    .i_memAck     (mem_ack),
    .i_memData    (mem_data),
    .i_redirect   (redirect),
    .i_redirectPc (redirect_pc),
    .o_instValid  (inst_valid),
    .o_instPc     (inst_pc),
    .o_inst       (inst),
    .i_instTake   (inst_take)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dword(input logic [31:0] a);
    return 32'hA500_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to the next falling edge, drop one-shot inputs, let outputs settle.
  task automatic cyc();
    @(negedge clk);
    mem_ack   = 1'b0;
    redirect  = 1'b0;
    inst_take = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; inst_take = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_memReq",    32'(mem_req),    32'd0);
    check("rst_memAddr",   mem_addr,        PC_INITIAL);
    check("rst_instValid", 32'(inst_valid), 32'd0);
    check("rst_instPc",    inst_pc,         32'd0);
    check("rst_inst",      inst,            32'd0);

    // Streaming with single-cycle acks
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("strm_memReq",  32'(mem_req), 32'd1);
      check("strm_memAddr", mem_addr,     32'(4 * i));
      if (i > 0) begin
        check("strm_valid", 32'(inst_valid), 32'd1);
        check("strm_pc",    inst_pc,         32'(4 * (i - 1)));
        check("strm_inst",  inst,            dword(32'(4 * (i - 1))));
        inst_take = 1'b1;
      end
      mem_ack  = 1'b1;
      mem_data = dword(32'(4 * i));
    end
    cyc();
    check("strm_last_pc",   inst_pc,                 32'h0000_000C);
    check("strm_last_inst", inst,                    dword(32'h0000_000C));
    check("strm_next_addr", mem_addr,                32'h0000_0010);
    check("strm_count",     32'(dut.u_fifo.o_count), 32'd1);

    // Fill without take
    do_reset();
    n_acks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (mem_req) begin
        n_acks++;
        mem_ack  = 1'b1;
        mem_data = dword(mem_addr);
      end
    end
    check("fill_reqs",   32'(n_acks),             32'd4);
    check("fill_memReq", 32'(mem_req),            32'd0);
    check("fill_count",  32'(dut.u_fifo.o_count), 32'd4);
    check("fill_headpc", inst_pc,                 32'd0);
    inst_take = 1'b1;
    cyc();
    check("take_headpc", inst_pc, 32'd4);
    n_acks = 0;
    last_addr = '0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (mem_req) begin
        n_acks++;
        last_addr = mem_addr;
        mem_ack   = 1'b1;
        mem_data  = dword(mem_addr);
      end
    end
    check("take_reqs",   32'(n_acks), 32'd1);
    check("take_addr",   last_addr,   32'h0000_0010);
    check("take_memReq", 32'(mem_req), 32'd0);

    // Redirect with a request in flight
    do_reset();
    cyc();
    check("rdf_issue", mem_addr, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cyc();
    check("rdf_state",   32'(dut.r_state), 32'(PFQ_DROP));
    check("rdf_memReq",  32'(mem_req),     32'd1);
    check("rdf_oldaddr", mem_addr,         32'd0);
    cyc();
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    cyc();
    check("rdf_idle_req", 32'(mem_req),    32'd0);
    check("rdf_novalid",  32'(inst_valid), 32'd0);
    cyc();
    check("rdf_newaddr", mem_addr, 32'h0000_0100);
    mem_ack = 1'b1; mem_data = dword(32'h0000_0100);
    cyc();
    check("rdf_valid", 32'(inst_valid), 32'd1);
    check("rdf_pc",    inst_pc,         32'h0000_0100);
    check("rdf_inst",  inst,            dword(32'h0000_0100));

    // Same-cycle redirect and ack
    do_reset();
    cyc();
    mem_ack = 1'b1; mem_data = dword(32'd0);
    cyc();
    check("rsa_headpc", inst_pc, 32'd0);
    mem_ack = 1'b1; mem_data = dword(32'd4);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; inst_take = 1'b1;
    cyc();
    check("rsa_flush_valid", 32'(inst_valid),         32'd0);
    check("rsa_flush_count", 32'(dut.u_fifo.o_count), 32'd0);
    check("rsa_memReq",      32'(mem_req),            32'd0);
    cyc();
    check("rsa_newreq",  32'(mem_req), 32'd1);
    check("rsa_newaddr", mem_addr,     32'h0000_0200);
    mem_ack = 1'b1; mem_data = dword(32'h0000_0200);
    cyc();
    check("rsa_pc",   inst_pc,  32'h0000_0200);
    check("rsa_next", mem_addr, 32'h0000_0204);

    // Asynchronous reset while a request is outstanding
    #2;
    rst = 1'b1;
    #1;
    check("arst_memReq",    32'(mem_req),    32'd0);
    check("arst_instValid", 32'(inst_valid), 32'd0);
    check("arst_memAddr",   mem_addr,        PC_INITIAL);
    check("arst_instPc",    inst_pc,         32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef PREFETCH_BYPASS_EN
    do_reset();
    cyc();
    mem_ack = 1'b1; mem_data = 32'h8C00_0000; inst_take = 1'b1;
    #1;
    check("byp_valid", 32'(inst_valid), 32'd1);
    check("byp_inst",  inst,            32'h8C00_0000);
    check("byp_pc",    inst_pc,         32'd0);
    cyc();
    check("byp_count",   32'(dut.u_fifo.o_count), 32'd0);
    check("byp_novalid", 32'(inst_valid),         32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
